// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: adder/subtractor that processes one 4-bit nibble per clock,
// LSB nibble first, with a one-cycle done pulse after the last nibble.
module nibble_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int IW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic             carry, last;
    logic [WIDTH-1:0] aop, bop, a_sh, b_sh, mask, sum_n;
    logic [IW+1:0]    sh;
    logic [4:0]       slice;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state == IDLE ? (start ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : IDLE;
    end
    assign busy  = state == RUN;
    assign done  = state == DONE;
    assign last  = idx == IW'(N - 1);
    assign sh    = {idx, 2'b00};
    assign a_sh  = aop >> sh;
    assign b_sh  = bop >> sh;
    assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
    assign mask  = {{(WIDTH-4){1'b0}}, 4'hF} << sh;
    // only the current nibble of sum is replaced; the rest holds
    assign sum_n = (sum & ~mask) | ({{(WIDTH-4){1'b0}}, slice[3:0]} << sh);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            aop   <= '0;
            bop   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == IDLE && start) begin
            aop   <= a;
            bop   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
        end else if (state == RUN) begin
            sum   <= sum_n;
            carry <= slice[4];
            idx   <= idx + IW'(1);
            if (last) begin
                cout <= slice[4];
                ovf  <= (aop[WIDTH-1] == bop[WIDTH-1]) && (sum_n[WIDTH-1] != aop[WIDTH-1]);
                zero <= sum_n == '0;
            end
        end
    end
endmodule

// File: doc/nibble_adder_seq.md
NIBBLE_ADDER_SEQ -- requirements
Module: nibble_adder_seq

Interface
REQ-001 Parameter WIDTH, default 16, is the operand width in bits; it SHALL be a multiple of 4 and at least 8; N = WIDTH/4 nibbles.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 Port sub, input, 1 bit: 0 selects A+B, 1 selects A-B; captured with start.
REQ-006 Port a, input, WIDTH bits: operand A, captured with start.
REQ-007 Port b, input, WIDTH bits: operand B, captured with start.
REQ-008 Port busy, output, 1 bit: high while in RUN.
REQ-009 Port done, output, 1 bit: single-cycle completion pulse.
REQ-010 Port sum, output, WIDTH bits: result register.
REQ-011 Port cout, output, 1 bit: carry out of bit WIDTH-1 (for sub, 1 = no borrow).
REQ-012 Port ovf, output, 1 bit: two's-complement signed overflow.
REQ-013 Port zero, output, 1 bit: high when the final sum is 0.

Function
REQ-014 The block SHALL be an FSM with three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge -> capture a, the B operand (b inverted when sub=1), and a carry register set to sub; clear nibble index to 0; go to RUN.
REQ-016 Each edge in RUN -> add nibble[idx] of A and B through one 4-bit adder slice with the carry register; write the 4-bit result into sum[4*idx+3:4*idx]; load the slice carry-out into the carry register; increment idx.
REQ-017 When the edge processes idx = N-1 -> go to DONE, and at that same edge load cout, ovf and zero from the completed result.
REQ-018 DONE -> done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, busy SHALL be high from E0 to EN and done SHALL be high from EN to EN+1; for WIDTH=16 that is 4 cycles; throughput is one operation per N+2 cycles.
REQ-020 start in RUN or DONE SHALL be ignored, with no queuing; a start held high is accepted again only on re-entering IDLE.
REQ-021 Changes on a, b or sub after capture SHALL NOT affect the result.
REQ-022 ovf = (A_msb == Bop_msb) && (sum_msb != A_msb), where Bop is the possibly inverted B.
REQ-023 zero = (sum == 0) for the completed result.
REQ-024 sum nibbles SHALL update progressively during RUN; sum, cout, ovf and zero SHALL then hold until the next accepted start.
REQ-025 cout, ovf and zero SHALL keep their previous values during RUN.
REQ-026 The next start SHALL NOT clear sum before the first RUN edge overwrites nibble 0.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, idx 0, carry 0, busy 0, done 0, sum 0, cout 0, ovf 0 and zero 0, independent of clk.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-029 start sampled at the first edge after rst deasserts SHALL be accepted.

Verification
REQ-030 a=0x1234, b=0x0FFF, sub=0 -> done 4 cycles after start; sum=0x2233, cout=0, ovf=0, zero=0.
REQ-031 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1.
REQ-032 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 a=0x0005, b=0x0005, sub=1 -> sum=0x0000, cout=1, zero=1.
REQ-034 Hold start high while changing a and b every cycle during RUN -> result reflects the captured operands; exactly one done per N+2 cycles; busy never high with done.
REQ-035 Assert rst for 1 cycle after the second RUN edge -> all outputs 0 at once, no done pulse; the next start with 0x1234+0x0FFF gives 0x2233.
